// File: rtl/mine_placer.sv
// mine_placer: seedable XNOR-LFSR mine-map generator for MineSweeper.
// Places exactly num_mines distinct mines into a CELLS-bit map on start.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, num_mines     begin a run and the mine count sampled with it
//   load_seed, seed      reseed the free-running LFSR
//   safe_idx             first-click cell kept mine-free (feature only)
//   busy, done, error    placing / map valid / last start rejected
//   mine_map             bit i set = cell i holds a mine
//
// Build option: define MINE_SAFE_CELL_EN to exclude safe_idx from
// placement (maximum count becomes CELLS-1).
module mine_placer #(
    parameter int                CELLS  = 64,
    parameter int                IDX_W  = 6,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hD008
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [IDX_W:0]   num_mines,
    input  logic             load_seed,
    input  logic [LFSR_W-1:0] seed,
    input  logic [IDX_W-1:0] safe_idx,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CELLS-1:0] mine_map
);

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        DONE
    } state_t;

`ifdef MINE_SAFE_CELL_EN
    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(CELLS - 1);
`else
    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(CELLS);
`endif

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CELLS-1:0]    map_q, map_d;
    logic [IDX_W:0]      cnt_q, cnt_d;
    logic [IDX_W:0]      n_q, n_d;
    logic                err_q, err_d;

    logic                fb;
    logic [IDX_W-1:0]    cand;
    logic                cand_ok;

    // XNOR feedback: the all-ones state is the lockup value.
    assign fb   = ~^(lfsr_q & TAPS);
    assign cand = lfsr_q[IDX_W-1:0];

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        if (load_seed) begin
            lfsr_d = (seed == '1) ? '0 : seed;
        end
    end

    always_comb begin
        cand_ok = (32'(cand) < CELLS) && !map_q[cand];
`ifdef MINE_SAFE_CELL_EN
        if (cand == safe_idx) begin
            cand_ok = 1'b0;
        end
`endif
    end

`ifndef MINE_SAFE_CELL_EN
    logic unused_safe;
    assign unused_safe = ^safe_idx;
`endif

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    map_d = '0;
                    cnt_d = '0;
                    n_d   = num_mines;
                    if (num_mines > MAX_N) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else if (num_mines == '0) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = PLACE;
                        err_d   = 1'b0;
                    end
                end
            end
            PLACE: begin
                if (cand_ok) begin
                    map_d[cand] = 1'b1;
                    cnt_d       = cnt_q + (IDX_W+1)'(1);
                    if (cnt_d == n_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            map_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == PLACE);
    assign done     = (state_q == DONE);
    assign error    = err_q;
    assign mine_map = map_q;

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer.
// Reference: LFSR sequence from seed plus set-based mine placement.
module tb_mine_placer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [6:0]  num_mines;
    logic        load_seed;
    logic [15:0] seed;
    logic [5:0]  safe_idx;
    logic        busy;
    logic        done;
    logic        error;
    logic [63:0] mine_map;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] TAPS = 16'hD008;
`ifdef MINE_SAFE_CELL_EN
    localparam int SAFE = 27;
    localparam int MAXN = 63;
`else
    localparam int SAFE = -1;
    localparam int MAXN = 64;
`endif

    logic [63:0] first_map;
    int          first_k;

    mine_placer dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .num_mines (num_mines),
        .load_seed (load_seed),
        .seed      (seed),
        .safe_idx  (safe_idx),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mine_map  (mine_map)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[i] && TAPS[i]) ones++;
        end
        return {s[14:0], ((ones % 2) == 0)};
    endfunction

    // k = clock edges from the seed-load edge to the start edge.
    function automatic void model(input logic [15:0] sd, input int k,
                                  input int n, output logic [63:0] map,
                                  output int cyc);
        logic [15:0] s;
        int cnt;
        int c;
        s = (sd == 16'hFFFF) ? 16'h0 : sd;
        for (int i = 0; i < k; i++) s = step(s);
        map = '0;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 200000) begin
            c = int'(s[5:0]);
            cyc++;
            if (!map[c] && c != SAFE) begin
                map[c] = 1'b1;
                cnt++;
            end
            s = step(s);
        end
    endfunction

    task automatic do_run(input logic [15:0] sd, input int k, input int n,
                          input bit poke, output logic [63:0] got,
                          output int bcyc, output bit ok);
        @(negedge clk);
        load_seed = 1'b1;
        seed      = sd;
        @(negedge clk);
        load_seed = 1'b0;
        repeat (k - 1) @(negedge clk);
        start     = 1'b1;
        num_mines = 7'(n);
        @(negedge clk);
        start = 1'b0;
        bcyc  = 0;
        ok    = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
            if (poke && busy && bcyc == 3) begin
                start     = 1'b1;
                num_mines = 7'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        got   = mine_map;
    endtask

    task automatic check_run(input string nm, input logic [15:0] sd,
                             input int k, input int n, input bit poke,
                             output logic [63:0] got);
        logic [63:0] exp_map;
        int exp_cyc;
        int bcyc;
        bit ok;
        model(sd, k, n, exp_map, exp_cyc);
        do_run(sd, k, n, poke, got, bcyc, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got done=%0b want 1", nm, ok);
        end
        checks++;
        if (got !== exp_map) begin
            errors++;
            $display("FAIL %s_map: got %h want %h", nm, got, exp_map);
        end
        checks++;
        if (bcyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_busy: got %0d want %0d", nm, bcyc, exp_cyc);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        start     = 1'b0;
        load_seed = 1'b0;
        num_mines = '0;
        seed      = '0;
        safe_idx  = 6'd27;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (mine_map !== 64'h0) begin
            errors++;
            $display("FAIL reset_map: got %h want 0", mine_map);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b want 0", error);
        end
    endtask

    task automatic test_place();
        logic [63:0] got;
        logic [63:0] em;
        int ec;
        first_k = int'($urandom_range(1, 40));
        model(16'h1234, first_k, 10, em, ec);
        check_run("n10", 16'h1234, first_k, 10, 1'b0, got);
        first_map = got;
        checks++;
        if ($countones(got) != 10) begin
            errors++;
            $display("FAIL n10_pop: got %0d want 10", $countones(got));
        end
        checks++;
        if (ec < 10) begin
            errors++;
            $display("FAIL n10_len: got %0d want >=10", ec);
        end
    endtask

    task automatic test_repeat();
        logic [63:0] got;
        check_run("same", 16'h1234, first_k, 10, 1'b0, got);
        checks++;
        if (got !== first_map) begin
            errors++;
            $display("FAIL same_seed: got %h want %h", got, first_map);
        end
        check_run("other", 16'h4321, first_k, 10, 1'b0, got);
        checks++;
        if (got === first_map) begin
            errors++;
            $display("FAIL other_seed: got %h want not %h", got, first_map);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        start     = 1'b1;
        num_mines = 7'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_state: got done=%b busy=%b want 1 0",
                     done, busy);
        end
        checks++;
        if (mine_map !== 64'h0) begin
            errors++;
            $display("FAIL zero_map: got %h want 0", mine_map);
        end
    endtask

    task automatic test_full();
        logic [63:0] got;
        logic [63:0] want;
`ifdef MINE_SAFE_CELL_EN
        want = ~(64'b1 << 27);
        check_run("full", 16'hBEEF, 3, 63, 1'b0, got);
`else
        want = 64'hFFFF_FFFF_FFFF_FFFF;
        check_run("full", 16'hBEEF, 3, 64, 1'b0, got);
`endif
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL full_map: got %h want %h", got, want);
        end
    endtask

    task automatic test_error();
        logic [63:0] got;
        int n;
        n = int'($urandom_range(MAXN + 1, 127));
        @(negedge clk);
        start     = 1'b1;
        num_mines = 7'(n);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL err_flag: got %b want 1 (n=%0d)", error, n);
        end
        checks++;
        if (mine_map !== 64'h0) begin
            errors++;
            $display("FAIL err_map: got %h want 0", mine_map);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: got busy=%b done=%b want 0 0",
                     busy, done);
        end
        check_run("after_err", 16'h0F0F, 2, 3, 1'b0, got);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", error);
        end
    endtask

    task automatic test_start_in_place();
        logic [63:0] got;
        check_run("poke", 16'hA5A5, 5, 20, 1'b1, got);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        load_seed = 1'b1;
        seed      = 16'h7777;
        @(negedge clk);
        load_seed = 1'b0;
        start     = 1'b1;
        num_mines = 7'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start     = 1'b1;
        num_mines = 7'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            mine_map !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset: got b=%b d=%b e=%b map=%h want 0",
                     busy, done, error, mine_map);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] got;
        check_run("lockup", 16'hFFFF, 4, 5, 1'b0, got);
        for (int i = 0; i < 6; i++) begin
            check_run("rand", 16'($urandom),
                      int'($urandom_range(1, 30)),
                      int'($urandom_range(0, MAXN)), 1'b0, got);
        end
    endtask

    initial begin
        test_reset();
        test_place();
        test_repeat();
        test_zero();
        test_full();
        test_error();
        test_start_in_place();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
